// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the RV32I pipeline front end.
`default_nettype none

package core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load / bubble / hold control.
`default_nettype none

module if_id_reg
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ifid_op_t    op,
  input  logic [31:0] ins_d,
  input  logic [31:0] pc_d,
  output logic [31:0] ins,
  output logic [31:0] pc_id,
  output logic        ifid_valid
);

  // A bubble only kills the instruction; pc_id keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ins        <= NOP_INSTR;
      pc_id      <= 32'h0000_0000;
      ifid_valid <= 1'b0;
    end else begin
      case (op)
        IFID_LOAD: begin
          ins        <= ins_d;
          pc_id      <= pc_d;
          ifid_valid <= 1'b1;
        end
        IFID_BUBBLE: begin
          ins        <= NOP_INSTR;
          ifid_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// fetch_stage: PC, req/ack instruction fetch FSM, stall hold buffer and
// IF/ID register for the 5-stage RV32I core.
`default_nettype none

module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] pc_id,
  output logic        ifid_valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  stale_addr;
  logic [31:0]  hold_buf;

  ifid_op_t     ifid_op;
  logic [31:0]  ifid_ins_d;
  logic         commit;

  // In DROP the memory still owns the old request, so its address must
  // stay on the bus even though pc already points at the branch target.
  assign imem_req  = (state == REQ) || (state == DROP);
  assign imem_addr = (state == DROP) ? stale_addr : pc;

  always_comb begin
    ifid_op    = IFID_HOLD;
    ifid_ins_d = hold_buf;
    commit     = 1'b0;
    if (flush) begin
      ifid_op = IFID_BUBBLE;
    end else begin
      case (state)
        REQ: begin
          if (imem_ack && IFIDWrite) begin
            ifid_op    = IFID_LOAD;
            ifid_ins_d = imem_rdata;
            commit     = 1'b1;
          end else if (!imem_ack && IFIDWrite) begin
            ifid_op = IFID_BUBBLE;
          end
        end
        HELD: begin
          if (IFIDWrite) begin
            ifid_op    = IFID_LOAD;
            ifid_ins_d = hold_buf;
            commit     = 1'b1;
          end
        end
        DROP:    ifid_op = IFID_BUBBLE;
        default: ifid_op = IFID_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= word_align(RESET_PC);
      stale_addr <= 32'h0000_0000;
      hold_buf   <= NOP_INSTR;
    end else if (flush) begin
      pc       <= branch_target & ~32'h0000_0003;
      hold_buf <= NOP_INSTR;
      case (state)
        REQ: begin
          if (imem_ack) begin
            state <= REQ;
          end else begin
            state      <= DROP;
            stale_addr <= pc;
          end
        end
        DROP:    state <= imem_ack ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      if (commit && PCWrite) begin
        pc <= pc + 32'd4;
      end
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ack && !IFIDWrite) begin
            hold_buf <= imem_rdata;
            state    <= HELD;
          end
        end
        HELD: begin
          if (IFIDWrite) begin
            state <= REQ;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .op         (ifid_op),
    .ins_d      (ifid_ins_d),
    .pc_d       (pc),
    .ins        (ins),
    .pc_id      (pc_id),
    .ifid_valid (ifid_valid)
  );

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core. It holds the PC, fetches instructions over a req/ack instruction-memory handshake, and presents `ins`/`pc_id` to decode. It directly consumes `PCWrite`/`IFIDWrite` from `hazard_detection_unit` (load-use stall) and `flush`/`branch_target` from EX (taken branch/jump). `ins` feeds the hazard unit's `ins` input.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `PCWrite`  in  1  1 = PC may advance; 0 = hold PC
- `IFIDWrite`  in  1  1 = IF/ID may load; 0 = hold IF/ID
- `flush`  in  1  redirect fetch to `branch_target`, kill IF/ID
- `branch_target`  in  32  redirect address
- `imem_req`  out  1  instruction-memory request valid
- `imem_addr`  out  32  request address (word aligned)
- `imem_ack`  in  1  response valid, one cycle per request
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`
- `ins`  out  32  IF/ID instruction
- `pc_id`  out  32  IF/ID PC of `ins`
- `ifid_valid`  out  1  `ins` is a real instruction, not a bubble

## Operation
- Single clock; synchronous active-high reset; all outputs registered except `imem_req`/`imem_addr` (decoded from state/PC).
- Reset values: `pc`=RESET_PC, `ins`=32'h0000_0013 (NOP), `pc_id`=0, `ifid_valid`=0, state=IDLE, `imem_req`=0, hold buffer=NOP.
- States: IDLE, REQ, HELD, DROP.
- IDLE: `imem_req`=0; next cycle -> REQ.
- REQ: `imem_req`=1, `imem_addr`=pc. Request stays stable until `imem_ack`.
  - ack & IFIDWrite: commit (`ins`<=rdata, `pc_id`<=pc, `ifid_valid`<=1); pc<=pc+4 if PCWrite; stay REQ (back-to-back).
  - ack & !IFIDWrite: rdata -> hold buffer, pc unchanged; -> HELD.
  - no ack & IFIDWrite: IF/ID loads bubble (NOP, valid=0).
  - no ack & !IFIDWrite: IF/ID holds.
- HELD: `imem_req`=0. IFIDWrite=1: commit from buffer, pc<=pc+4 if PCWrite, -> REQ. Else IF/ID holds, stay HELD.
- DROP: `imem_req`=1 with the old address (stale request in flight); IF/ID loads bubble; on ack data discarded -> REQ.
- PC advances only on a commit with PCWrite=1; PCWrite=1 without commit does nothing.
- flush (highest priority, overrides stall): pc<=branch_target with bits[1:0] forced 0; IF/ID<=NOP, valid=0; hold buffer discarded.
  - In REQ without ack: -> DROP. In REQ with ack same cycle: data discarded -> REQ. In HELD/IDLE: -> REQ. In DROP: pc updated again, stay DROP unless ack (-> REQ).
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Reset in any state abandons any outstanding request; `imem_req` is 0 the cycle after.

## Timing
- Ack in cycle N -> `ins`/`pc_id`/`ifid_valid` valid from cycle N+1.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, new `imem_addr` every cycle.
- First request: `imem_req` rises in the 2nd cycle after `rst` deasserts (IDLE -> REQ).
- Stall released in HELD: buffered word appears on `ins` the next cycle; new request issues the cycle after release.
- Flush at edge N: `ins`=NOP, `ifid_valid`=0 from N+1; target request issued from N+1 (REQ) or after the stale ack (DROP).

## Structure
- Shared package `core_pkg`: `NOP_INSTR`=32'h0000_0013, `RESET_PC` default, fetch state enum (IDLE, REQ, HELD, DROP).
- One sub-module `if_id_reg`: IF/ID register with load/bubble/hold controls and reset to NOP; `fetch_stage` holds PC, FSM, and hold buffer.

## Test plan
- Reset, zero-wait memory, stall/flush low -> `imem_addr` 0,4,8,…; `ins` follows rdata one cycle later, `pc_id` matches, `ifid_valid`=1.
- Load-use stall: PCWrite=IFIDWrite=0 for 1 cycle at pc=8 -> `ins`/`pc_id`=4 held, pc stays 8, next commit `pc_id`=8, no instruction lost or duplicated.
- Stall coinciding with ack (2-wait memory) -> state HELD, `imem_req`=0; on release `ins`=buffered word, following request addr=pc+4.
- Flush with branch_target=32'h0000_0103 while REQ outstanding -> DROP, stale data discarded, next request addr 32'h0000_0100, `ifid_valid`=0 until its commit.
- Flush and stall same cycle -> flush wins: IF/ID NOP, pc=target.
- pc=32'hFFFF_FFFC commit -> next `imem_addr`=0; `rst` pulse mid-REQ -> `imem_req`=0 next cycle, `ins`=NOP, pc=RESET_PC.
